// File: rtl/stack_ctrl.sv
// ---------------------------------------------------------------------------
// stack_ctrl
//   Sequencer for PUSH/POP commands onto a memory-resident stack whose
//   pointer lives in a register-file entry (SP_REG). A PUSH stores the value
//   at the current SP and then decrements SP. A POP first increments SP and
//   then reads the value at the new SP into the destination register.
//
//   Optional feature macro: STACK_BOUNDS_CHECK_EN
//     defined   : PUSH at SP==8'h00 or POP at SP==8'hFF goes to a one-cycle
//                 ERR state (done=1, err=1, no memory/register-file access).
//     undefined : no ERR state, err tied low, SP arithmetic wraps mod 256.
//
//   All outputs except err (when the check is disabled) are registered and
//   depend only on the current state, so done/err are Moore pulses.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | cmd_ready=1, waiting for a command
//   PUSH_MEM | memory write of cmd_data at SP, held until mem_ack
//   PUSH_SP  | register-file write SP_REG <= SP-1, done pulse
//   POP_SP   | register-file write SP_REG <= SP+1
//   POP_MEM  | memory read at SP+1, held until mem_ack, data captured
//   POP_WB   | register-file write cmd_reg <= captured data, done pulse
//   ERR      | bounds violation, done and err pulse (macro builds only)
// ---------------------------------------------------------------------------
module stack_ctrl #(
    parameter logic [1:0] SP_REG = 2'd3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_op,
    input  logic [7:0] cmd_data,
    input  logic [1:0] cmd_reg,
    input  logic [7:0] sp_in,
    output logic       rf_wr_en,
    output logic [1:0] rf_wr_addr,
    output logic [7:0] rf_wr_data,
    output logic       mem_req,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PUSH_MEM = 3'd1,
        PUSH_SP  = 3'd2,
        POP_SP   = 3'd3,
        POP_MEM  = 3'd4,
`ifdef STACK_BOUNDS_CHECK_EN
        POP_WB   = 3'd5,
        ERR      = 3'd6
`else
        POP_WB   = 3'd5
`endif
    } state_t;

    localparam logic OP_PUSH = 1'b0;

    state_t     state;
    // Latched command fields. The opcode itself is carried by the state
    // (PUSH_* vs POP_*), and the PUSH value is held in mem_wdata.
    logic [7:0] sp_q;
    logic [1:0] reg_q;

`ifndef STACK_BOUNDS_CHECK_EN
    // Without bounds checking no error can ever be raised.
    assign err = 1'b0;
`endif

    // Sequencer: next state and all registered outputs in one place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            sp_q       <= 8'h00;
            reg_q      <= 2'd0;
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= 2'd0;
            rf_wr_data <= 8'h00;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 8'h00;
            mem_wdata  <= 8'h00;
            done       <= 1'b0;
`ifdef STACK_BOUNDS_CHECK_EN
            err        <= 1'b0;
`endif
        end else begin
            // Strobes default low; each state re-asserts what it owns.
            cmd_ready <= 1'b0;
            rf_wr_en  <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            done      <= 1'b0;
`ifdef STACK_BOUNDS_CHECK_EN
            err       <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        sp_q      <= sp_in;
                        reg_q     <= cmd_reg;
                        mem_wdata <= cmd_data;
`ifdef STACK_BOUNDS_CHECK_EN
                        if (((cmd_op == OP_PUSH) && (sp_in == 8'h00)) ||
                            ((cmd_op != OP_PUSH) && (sp_in == 8'hFF))) begin
                            state <= ERR;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else
`endif
                        if (cmd_op == OP_PUSH) begin
                            state    <= PUSH_MEM;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b1;
                            mem_addr <= sp_in;
                        end else begin
                            state      <= POP_SP;
                            rf_wr_en   <= 1'b1;
                            rf_wr_addr <= SP_REG;
                            rf_wr_data <= sp_in + 8'd1;
                        end
                    end
                end

                PUSH_MEM: begin
                    if (mem_ack) begin
                        state      <= PUSH_SP;
                        rf_wr_en   <= 1'b1;
                        rf_wr_addr <= SP_REG;
                        rf_wr_data <= sp_q - 8'd1;
                        done       <= 1'b1;
                    end else begin
                        // Address and data registers simply hold.
                        mem_req <= 1'b1;
                        mem_we  <= 1'b1;
                    end
                end

                PUSH_SP: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end

                POP_SP: begin
                    state    <= POP_MEM;
                    mem_req  <= 1'b1;
                    mem_addr <= sp_q + 8'd1;
                end

                POP_MEM: begin
                    if (mem_ack) begin
                        // Read data is captured straight into the write port.
                        state      <= POP_WB;
                        rf_wr_en   <= 1'b1;
                        rf_wr_addr <= reg_q;
                        rf_wr_data <= mem_rdata;
                        done       <= 1'b1;
                    end else begin
                        mem_req <= 1'b1;
                    end
                end

                POP_WB: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end

`ifdef STACK_BOUNDS_CHECK_EN
                ERR: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
`endif

                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stack_ctrl
//   Directed vector table, reset corner sequences and a randomized run
//   checked against a LIFO model of the stack.
//   Honors STACK_BOUNDS_CHECK_EN for the bounds vectors.
// ---------------------------------------------------------------------------
module tb_stack_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_op = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic [1:0] cmd_reg = 2'd0;
    logic [7:0] sp_in = 8'h00;
    logic       rf_wr_en;
    logic [1:0] rf_wr_addr;
    logic [7:0] rf_wr_data;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_ack = 1'b0;
    logic       done;
    logic       err;

    stack_ctrl #(.SP_REG(2'd3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_reg    (cmd_reg),
        .sp_in      (sp_in),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         op;
        logic [7:0] data;
        logic [1:0] rg;
        logic [7:0] sp;
        int         delay;
        logic [7:0] rdata;
        int         e_lat;
        int         e_memcyc;
        logic [7:0] e_maddr;
        bit         e_mwe;
        int         e_nrf;
        logic [1:0] e_a0;
        logic [7:0] e_d0;
        logic [1:0] e_a1;
        logic [7:0] e_d1;
        bit         e_err;
    } vec_t;

    typedef struct {
        bit              timeout;
        int              latency;
        int              mem_cycles;
        logic [7:0]      mem_addr;
        logic            mem_we;
        logic [7:0]      mem_wdata;
        bit              unstable;
        int              n_rf;
        logic [3:0][1:0] rf_addr;
        logic [3:0][7:0] rf_data;
        int              n_done;
        int              done_cyc;
        int              n_err;
    } obs_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory behind the controller; written by observed PUSH writes.
    logic [7:0] mem_env [256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one command and record everything the DUT does until cmd_ready returns.
    task automatic run_cmd(input bit op, input logic [7:0] data, input logic [1:0] rg,
                           input logic [7:0] sp, input int delay, input logic [7:0] rdata,
                           input bit use_env, input bit spurious, output obs_t o);
        int w;
        o.timeout = 0; o.latency = 0; o.mem_cycles = 0; o.mem_addr = 0; o.mem_we = 0;
        o.mem_wdata = 0; o.unstable = 0; o.n_rf = 0; o.rf_addr = '0; o.rf_data = '0;
        o.n_done = 0; o.done_cyc = 0; o.n_err = 0;
        @(negedge clk);
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            o.timeout = 1;
            return;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_reg = rg; sp_in = sp;
        @(negedge clk);
        // Scramble inputs after acceptance: the DUT must use its latched copies.
        cmd_valid = 1'b0; cmd_op = 1'($urandom); cmd_data = 8'($urandom);
        cmd_reg = 2'($urandom); sp_in = 8'($urandom);
        for (int c = 1; c <= 40; c++) begin
            if (mem_req) begin
                if (o.mem_cycles == 0) begin
                    o.mem_addr = mem_addr; o.mem_we = mem_we; o.mem_wdata = mem_wdata;
                end else if (mem_addr !== o.mem_addr || mem_we !== o.mem_we ||
                             (mem_we && mem_wdata !== o.mem_wdata)) begin
                    o.unstable = 1;
                end
                if (o.mem_cycles == delay) begin
                    mem_ack = 1'b1;
                    if (mem_we) mem_env[mem_addr] = mem_wdata;
                    mem_rdata = use_env ? mem_env[mem_addr] : rdata;
                end else begin
                    mem_ack = 1'b0;
                    mem_rdata = 8'($urandom);
                end
                o.mem_cycles++;
            end else begin
                mem_ack = spurious ? 1'($urandom) : 1'b0;
                mem_rdata = 8'($urandom);
            end
            if (rf_wr_en) begin
                if (o.n_rf < 4) begin
                    o.rf_addr[o.n_rf] = rf_wr_addr;
                    o.rf_data[o.n_rf] = rf_wr_data;
                end
                o.n_rf++;
            end
            if (done) begin
                o.n_done++;
                o.done_cyc = c;
            end
            if (err) o.n_err++;
            if (cmd_ready) begin
                o.latency = c;
                break;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        if (o.latency == 0) o.timeout = 1;
    endtask

    task automatic compare(input string tag, input vec_t v, input obs_t o);
        check({tag, "_timeout"}, o.timeout, 0);
        check({tag, "_latency"}, o.latency, v.e_lat);
        check({tag, "_mem_cycles"}, o.mem_cycles, v.e_memcyc);
        if (v.e_memcyc > 0) begin
            check({tag, "_mem_addr"}, o.mem_addr, v.e_maddr);
            check({tag, "_mem_we"}, o.mem_we, v.e_mwe);
            check({tag, "_mem_stable"}, o.unstable, 0);
            if (!v.op) check({tag, "_mem_wdata"}, o.mem_wdata, v.data);
        end
        check({tag, "_rf_writes"}, o.n_rf, v.e_nrf);
        if (v.e_nrf > 0) begin
            check({tag, "_rf0_addr"}, o.rf_addr[0], v.e_a0);
            check({tag, "_rf0_data"}, o.rf_data[0], v.e_d0);
        end
        if (v.e_nrf > 1) begin
            check({tag, "_rf1_addr"}, o.rf_addr[1], v.e_a1);
            check({tag, "_rf1_data"}, o.rf_data[1], v.e_d1);
        end
        check({tag, "_done_count"}, o.n_done, 1);
        check({tag, "_done_cycle"}, o.done_cyc, v.e_lat - 1);
        check({tag, "_err_count"}, o.n_err, v.e_err);
    endtask

    vec_t       vecs [8];
    obs_t       ob;
    logic [7:0] stk [$];
    logic [7:0] sp_m;
    int         bad;

    initial begin
        // Directed vectors: op data rg sp delay rdata | lat memcyc maddr we nrf a0 d0 a1 d1 err
        vecs[0] = '{1'b0, 8'h55, 2'd0, 8'hFF, 0, 8'h00, 3, 1, 8'hFF, 1'b1, 1, 2'd3, 8'hFE, 2'd0, 8'h00, 1'b0};
        vecs[1] = '{1'b1, 8'h00, 2'd1, 8'hFE, 2, 8'hAA, 6, 3, 8'hFF, 1'b0, 2, 2'd3, 8'hFF, 2'd1, 8'hAA, 1'b0};
        vecs[2] = '{1'b1, 8'h00, 2'd3, 8'hFD, 0, 8'h77, 4, 1, 8'hFE, 1'b0, 2, 2'd3, 8'hFE, 2'd3, 8'h77, 1'b0};
        vecs[3] = '{1'b0, 8'hA5, 2'd0, 8'h10, 3, 8'h00, 6, 4, 8'h10, 1'b1, 1, 2'd3, 8'h0F, 2'd0, 8'h00, 1'b0};
        vecs[4] = '{1'b1, 8'h00, 2'd0, 8'h00, 1, 8'h3C, 5, 2, 8'h01, 1'b0, 2, 2'd3, 8'h01, 2'd0, 8'h3C, 1'b0};
`ifdef STACK_BOUNDS_CHECK_EN
        vecs[5] = '{1'b0, 8'h12, 2'd0, 8'h00, 0, 8'h00, 2, 0, 8'h00, 1'b0, 0, 2'd0, 8'h00, 2'd0, 8'h00, 1'b1};
        vecs[6] = '{1'b1, 8'h00, 2'd2, 8'hFF, 0, 8'h99, 2, 0, 8'h00, 1'b0, 0, 2'd0, 8'h00, 2'd0, 8'h00, 1'b1};
`else
        vecs[5] = '{1'b0, 8'h12, 2'd0, 8'h00, 0, 8'h00, 3, 1, 8'h00, 1'b1, 1, 2'd3, 8'hFF, 2'd0, 8'h00, 1'b0};
        vecs[6] = '{1'b1, 8'h00, 2'd2, 8'hFF, 0, 8'h99, 4, 1, 8'h00, 1'b0, 2, 2'd3, 8'h00, 2'd2, 8'h99, 1'b0};
`endif
        vecs[7] = '{1'b1, 8'h00, 2'd2, 8'h20, 3, 8'h5E, 7, 4, 8'h21, 1'b0, 2, 2'd3, 8'h21, 2'd2, 8'h5E, 1'b0};

        for (int i = 0; i < 256; i++) mem_env[i] = 8'h00;

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_mem_req", mem_req, 0);
        check("reset_rf_wr_en", rf_wr_en, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_mem_we", mem_we, 0);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].op, vecs[i].data, vecs[i].rg, vecs[i].sp, vecs[i].delay,
                    vecs[i].rdata, 1'b0, 1'b1, ob);
            compare($sformatf("vec%0d", i), vecs[i], ob);
        end

        // Reset during PUSH_MEM with a pending ack across release.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_data = 8'h3C; sp_in = 8'h40;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rst_mid_req_before", mem_req, 1);
        #2 rst_n = 1'b0;
        mem_ack = 1'b1;
        #1;
        check("rst_mid_req_async", mem_req, 0);
        check("rst_mid_we_async", mem_we, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (rf_wr_en || mem_req || done || err) bad++;
        end
        mem_ack = 1'b0;
        check("rst_mid_no_access", bad, 0);
        check("rst_mid_ready", cmd_ready, 1);
        run_cmd(1'b0, 8'h5A, 2'd0, 8'h40, 0, 8'h00, 1'b0, 1'b0, ob);
        compare("post_reset_push",
                '{1'b0, 8'h5A, 2'd0, 8'h40, 0, 8'h00, 3, 1, 8'h40, 1'b1, 1, 2'd3, 8'h3F, 2'd0, 8'h00, 1'b0},
                ob);

        // Randomized run against a LIFO model of the stack.
        sp_m = 8'h80;
        for (int n = 0; n < 80; n++) begin
            vec_t e;
            int   d;
            bit   op;
            d  = $urandom_range(0, 3);
            op = (stk.size() == 0) ? 1'b0 : (stk.size() > 40) ? 1'b1 : 1'($urandom);
            e = '{1'b0, 8'h00, 2'd0, sp_m, d, 8'h00, 0, d + 1, 8'h00, 1'b0, 0, 2'd3, 8'h00, 2'd0, 8'h00, 1'b0};
            if (!op) begin
                e.data = 8'($urandom);
                e.e_lat = 3 + d; e.e_maddr = sp_m; e.e_mwe = 1'b1;
                e.e_nrf = 1; e.e_d0 = 8'(sp_m - 8'd1);
                run_cmd(1'b0, e.data, 2'd0, sp_m, d, 8'h00, 1'b1, 1'b1, ob);
                stk.push_back(e.data);
                sp_m = 8'(sp_m - 8'd1);
            end else begin
                e.op = 1'b1;
                e.rg = 2'($urandom_range(0, 2));
                e.e_lat = 4 + d; e.e_maddr = 8'(sp_m + 8'd1); e.e_mwe = 1'b0;
                e.e_nrf = 2; e.e_d0 = 8'(sp_m + 8'd1);
                e.e_a1 = e.rg; e.e_d1 = stk.pop_back();
                run_cmd(1'b1, 8'h00, e.rg, sp_m, d, 8'h00, 1'b1, 1'b1, ob);
                sp_m = 8'(sp_m + 8'd1);
            end
            compare($sformatf("rnd%0d", n), e, ob);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameter SP_REG, default 2'd3, meaning the register-file address holding the stack pointer.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-006 SHALL have port cmd_op  input  1  0 = PUSH, 1 = POP.
REQ-007 SHALL have port cmd_data  input  8  PUSH value.
REQ-008 SHALL have port cmd_reg  input  2  POP destination register.
REQ-009 SHALL have port sp_in  input  8  current stack pointer from the register file SP output.
REQ-010 SHALL have ports rf_wr_en  output  1, rf_wr_addr  output  2, rf_wr_data  output  8  register-file write port.
REQ-011 SHALL have ports mem_req  output  1, mem_we  output  1, mem_addr  output  8, mem_wdata  output  8  data-memory request.
REQ-012 SHALL have ports mem_rdata  input  8, mem_ack  input  1  memory completion; read data valid when mem_ack is high.
REQ-013 SHALL have ports done  output  1, err  output  1  completion and error pulses.

Function
REQ-014 SHALL implement FSM states IDLE, PUSH_MEM, PUSH_SP, POP_SP, POP_MEM, POP_WB, ERR.
REQ-015 SHALL assert cmd_ready only in IDLE; on acceptance it SHALL latch cmd_op, cmd_data, cmd_reg, and sp_in into internal registers.
REQ-016 PUSH SHALL go IDLE -> PUSH_MEM; PUSH_MEM SHALL hold mem_req=1, mem_we=1, mem_addr=latched SP, mem_wdata=cmd_data stable until the mem_ack cycle, then go to PUSH_SP.
REQ-017 PUSH_SP SHALL drive rf_wr_en=1, rf_wr_addr=SP_REG, rf_wr_data=SP-1 (mod 256) for one cycle, assert done, then return to IDLE.
REQ-018 POP SHALL go IDLE -> POP_SP, which writes SP+1 (mod 256) to SP_REG for one cycle, then goes to POP_MEM.
REQ-019 POP_MEM SHALL hold mem_req=1, mem_we=0, mem_addr=SP+1 until mem_ack, capture mem_rdata in the ack cycle, then go to POP_WB.
REQ-020 POP_WB SHALL write the captured data to cmd_reg for one cycle, assert done, then return to IDLE.
REQ-021 A POP with cmd_reg==SP_REG SHALL leave R3 holding the popped value, because the POP_WB write follows the POP_SP write.
REQ-022 Minimum accept-to-accept latency SHALL be 3 cycles for PUSH and 4 for POP (ack in the first memory cycle); each mem_ack wait cycle adds one.
REQ-023 mem_ack outside PUSH_MEM/POP_MEM SHALL be ignored.
REQ-024 Outside the stated states, rf_wr_en, mem_req, mem_we, done, and err SHALL be 0; data/address outputs are don't-care.
REQ-025 done and err SHALL be Moore outputs, each high for exactly one cycle per command.

Reset
REQ-026 rst_n low SHALL immediately force IDLE with rf_wr_en=0, mem_req=0, mem_we=0, done=0, err=0, cmd_ready=1 (after release), and all latched registers cleared to 0.
REQ-027 Reset during any non-IDLE state SHALL abandon the command with no further rf or memory access; a pending mem_ack after reset release SHALL be ignored.

Configuration
REQ-028 Macro STACK_BOUNDS_CHECK_EN, when defined, SHALL route a PUSH accepted with SP==8'h00 (overflow) or a POP accepted with SP==8'hFF (underflow) to ERR. ERR lasts one cycle with done=1, err=1, no memory or register-file access, then returns to IDLE.
REQ-029 Without STACK_BOUNDS_CHECK_EN, err SHALL be tied 0, the ERR state SHALL be absent, and SP arithmetic SHALL wrap modulo 256.

Verification
REQ-030 Reset, sp_in=FF, PUSH cmd_data=55, mem_ack on first cycle -> mem write addr FF data 55, then rf write R3=FE with done, cmd_ready again 3 cycles after accept.
REQ-031 sp_in=FE, POP cmd_reg=1, mem_ack delayed 2 cycles returning AA -> rf write R3=FF, mem read addr FF held 3 cycles, rf write R1=AA with done.
REQ-032 POP cmd_reg=3, sp_in=FD, mem_rdata=77 -> writes R3=FE then R3=77 on consecutive write cycles.
REQ-033 With STACK_BOUNDS_CHECK_EN: POP at sp_in=FF -> single-cycle done=1, err=1, no mem_req/rf_wr_en. PUSH at sp_in=00 -> same. Without the macro, PUSH at 00 -> writes SP=FF, err=0.
REQ-034 rst_n pulsed low during PUSH_MEM with mem_req=1 -> mem_req drops asynchronously, no rf write occurs, next PUSH completes normally.
